// File: rtl/clock_pkg.sv
// Shared widths, hour limits and load-value saturation for the time-of-day counter.
package clock_pkg;

  localparam int SEC_W     = 6;
  localparam int MIN_W     = 6;
  localparam int HR_W      = 5;
  localparam int HR_MAX_24 = 23;
  localparam int HR_MAX_12 = 12;

  // Clamp a load value to the largest legal count of its field.
  function automatic logic [5:0] saturate(input logic [5:0] value, input logic [5:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo counter: counts MIN_VAL..MAX_VAL, synchronous load wins over enable,
// and flags the cycle in which an enabled count wraps from MAX_VAL back to MIN_VAL.
module mod_counter #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   MIN_VAL = '0,
  parameter logic [W-1:0]   MAX_VAL = W'(59),
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load has priority, otherwise step with wrap back to the lowest value.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (count_q == MAX_VAL) begin
        count_d = MIN_VAL;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count register, asynchronously cleared to its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/time_of_day_counter.sv
// Seconds/minutes/hours time-of-day counter with tick divider, set mode,
// 12h/24h hours and registered rollover pulses.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter bit MODE_24H = 1'b1,
  parameter int TICK_DIV = 1,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            set,
  input  logic [SEC_W-1:0] set_sec,
  input  logic [MIN_W-1:0] set_min,
  input  logic [HR_W-1:0]  set_hr,
  input  logic            set_pm,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic            pm,
  output logic            min_pulse,
  output logic            hr_pulse,
  output logic            day_pulse
);

  localparam int              DIV_W    = 10;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MOD - 1);
  localparam logic [HR_W-1:0]  HR_FIRST = MODE_24H ? HR_W'(0) : HR_W'(1);
  localparam logic [HR_W-1:0]  HR_LAST  = MODE_24H ? HR_W'(HR_MAX_24) : HR_W'(HR_MAX_12);
  localparam logic [HR_W-1:0]  HR_RST   = MODE_24H ? HR_W'(0) : HR_W'(HR_MAX_12);
  localparam logic [HR_W-1:0]  HR_ELEVEN = HR_W'(11);

  logic [DIV_W-1:0] div_q, div_d;
  logic             advance;
  logic [SEC_W-1:0] sec_ld;
  logic [MIN_W-1:0] min_ld;
  logic [HR_W-1:0]  hr_ld;
  logic             sec_wrap, min_wrap, hr_wrap;
  logic             pm_q, pm_d;
  logic             min_pulse_q, min_pulse_d;
  logic             hr_pulse_q, hr_pulse_d;
  logic             day_pulse_q, day_pulse_d;
  logic             pm_turn;

  // Tick divider: only the TICK_DIV-th tick since the last advance (or set) advances time.
  always_comb begin
    div_d   = div_q;
    advance = 1'b0;
    if (set) begin
      div_d = '0;
    end else if (tick) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        advance = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Load values clamped into the legal range of each field.
  always_comb begin
    sec_ld = saturate(set_sec, SEC_LAST);
    min_ld = saturate(set_min, MIN_LAST);
    hr_ld  = set_hr;
    if (MODE_24H) begin
      hr_ld = HR_W'(saturate({1'b0, set_hr}, 6'(HR_MAX_24)));
    end else if ((set_hr == '0) || (set_hr > HR_W'(HR_MAX_12))) begin
      hr_ld = HR_W'(HR_MAX_12);
    end
  end

  mod_counter #(.W(SEC_W), .MIN_VAL('0), .MAX_VAL(SEC_LAST), .RST_VAL('0)) u_sec (
    .clk(clk), .rst(rst), .en(advance), .load(set), .load_val(sec_ld),
    .count(seconds), .wrap(sec_wrap)
  );

  mod_counter #(.W(MIN_W), .MIN_VAL('0), .MAX_VAL(MIN_LAST), .RST_VAL('0)) u_min (
    .clk(clk), .rst(rst), .en(sec_wrap), .load(set), .load_val(min_ld),
    .count(minutes), .wrap(min_wrap)
  );

  // In 12h mode the hours counter runs 1..12 and wraps 12->1; the 11->12 step is handled below.
  mod_counter #(.W(HR_W), .MIN_VAL(HR_FIRST), .MAX_VAL(HR_LAST), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .rst(rst), .en(min_wrap), .load(set), .load_val(hr_ld),
    .count(hours), .wrap(hr_wrap)
  );

  // Next pm flag and rollover pulses; 11->12 in 12h mode flips am/pm, and PM->AM ends the day.
  always_comb begin
    pm_turn     = !MODE_24H && min_wrap && (hours == HR_ELEVEN);
    pm_d        = pm_q;
    min_pulse_d = sec_wrap;
    hr_pulse_d  = min_wrap;
    day_pulse_d = MODE_24H ? hr_wrap : (pm_turn && pm_q);
    if (set) begin
      pm_d = MODE_24H ? 1'b0 : set_pm;
    end else if (pm_turn) begin
      pm_d = ~pm_q;
    end
  end

  // pm and pulse registers, aligned with the counter update they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q        <= 1'b0;
      min_pulse_q <= 1'b0;
      hr_pulse_q  <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      min_pulse_q <= min_pulse_d;
      hr_pulse_q  <= hr_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign pm        = pm_q;
  assign min_pulse = min_pulse_q;
  assign hr_pulse  = hr_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: three instances (24h, 12h, 24h with TICK_DIV=4)
// share one stimulus stream and are compared with a seconds-of-day reference model.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       set = 1'b0;
  logic [5:0] set_sec = '0;
  logic [5:0] set_min = '0;
  logic [4:0] set_hr = '0;
  logic       set_pm = 1'b0;

  logic [5:0] sec_o [3];
  logic [5:0] min_o [3];
  logic [4:0] hr_o  [3];
  logic       pm_o  [3];
  logic       mp_o  [3];
  logic       hp_o  [3];
  logic       dp_o  [3];

  int total = 0;
  int bad   = 0;

  // Reference model: hr24 is always 0..23; 12h display is derived from it.
  int m_sec [3];
  int m_min [3];
  int m_hr24[3];
  int m_div [3];
  bit m_mp  [3];
  bit m_hp  [3];
  bit m_dp  [3];

  always #5 clk = ~clk;

  time_of_day_counter #(.MODE_24H(1'b1), .TICK_DIV(1), .SEC_MOD(60), .MIN_MOD(60)) dut24 (
    .clk(clk), .rst(rst), .tick(tick), .set(set), .set_sec(set_sec), .set_min(set_min),
    .set_hr(set_hr), .set_pm(set_pm), .seconds(sec_o[0]), .minutes(min_o[0]), .hours(hr_o[0]),
    .pm(pm_o[0]), .min_pulse(mp_o[0]), .hr_pulse(hp_o[0]), .day_pulse(dp_o[0])
  );

  time_of_day_counter #(.MODE_24H(1'b0), .TICK_DIV(1), .SEC_MOD(60), .MIN_MOD(60)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .set(set), .set_sec(set_sec), .set_min(set_min),
    .set_hr(set_hr), .set_pm(set_pm), .seconds(sec_o[1]), .minutes(min_o[1]), .hours(hr_o[1]),
    .pm(pm_o[1]), .min_pulse(mp_o[1]), .hr_pulse(hp_o[1]), .day_pulse(dp_o[1])
  );

  time_of_day_counter #(.MODE_24H(1'b1), .TICK_DIV(4), .SEC_MOD(60), .MIN_MOD(60)) dutdiv (
    .clk(clk), .rst(rst), .tick(tick), .set(set), .set_sec(set_sec), .set_min(set_min),
    .set_hr(set_hr), .set_pm(set_pm), .seconds(sec_o[2]), .minutes(min_o[2]), .hours(hr_o[2]),
    .pm(pm_o[2]), .min_pulse(mp_o[2]), .hr_pulse(hp_o[2]), .day_pulse(dp_o[2])
  );

  function automatic int div_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic bit is24(input int i);
    return (i != 1);
  endfunction

  function automatic int exp_hr(input int i);
    if (is24(i)) return m_hr24[i];
    return ((m_hr24[i] % 12) == 0) ? 12 : (m_hr24[i] % 12);
  endfunction

  function automatic bit exp_pm(input int i);
    return !is24(i) && (m_hr24[i] >= 12);
  endfunction

  task model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sec[i] = 0; m_min[i] = 0; m_hr24[i] = 0; m_div[i] = 0;
      m_mp[i] = 0; m_hp[i] = 0; m_dp[i] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task model_clock();
    int t;
    int h;
    for (int i = 0; i < 3; i++) begin
      m_mp[i] = 0; m_hp[i] = 0; m_dp[i] = 0;
      if (set) begin
        m_sec[i] = (set_sec > 59) ? 59 : int'(set_sec);
        m_min[i] = (set_min > 59) ? 59 : int'(set_min);
        if (is24(i)) begin
          m_hr24[i] = (set_hr > 23) ? 23 : int'(set_hr);
        end else begin
          h = (set_hr == 0 || set_hr > 12) ? 12 : int'(set_hr);
          m_hr24[i] = (h % 12) + (set_pm ? 12 : 0);
        end
        m_div[i] = 0;
      end else if (tick) begin
        if (m_div[i] == div_of(i) - 1) begin
          m_div[i] = 0;
          m_mp[i] = (m_sec[i] == 59);
          m_hp[i] = m_mp[i] && (m_min[i] == 59);
          m_dp[i] = m_hp[i] && (m_hr24[i] == 23);
          t = m_hr24[i] * 3600 + m_min[i] * 60 + m_sec[i] + 1;
          t = t % 86400;
          m_hr24[i] = t / 3600;
          m_min[i]  = (t / 60) % 60;
          m_sec[i]  = t % 60;
        end else begin
          m_div[i] = m_div[i] + 1;
        end
      end
    end
  endtask

  task step(input bit t);
    tick = t;
    @(posedge clk);
    model_clock();
    #1;
    tick = 1'b0;
  endtask

  task load_time(input int h, input int m, input int s, input bit p);
    set = 1'b1; set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_pm = p;
    step(1'b0);
    set = 1'b0;
  endtask

  task test_reset();
    logic [17:0] got, exp;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      got = {hr_o[i], min_o[i], sec_o[i], pm_o[i]};
      exp = {(is24(i) ? 5'd0 : 5'd12), 6'd0, 6'd0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL reset_time dut%0d got=%0d:%0d:%0d pm%0b want=%0d:00:00 pm0",
                 i, hr_o[i], min_o[i], sec_o[i], pm_o[i], exp[17:13]);
      end
      total++;
      if ({mp_o[i], hp_o[i], dp_o[i]} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_pulses dut%0d got=%b want=000", i, {mp_o[i], hp_o[i], dp_o[i]});
      end
    end
    rst = 1'b1;
  endtask

  task test_count_60();
    int pulses;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      step(1'b1);
      pulses += int'(mp_o[0]);
      total++;
      if (sec_o[0] !== 6'(k % 60) || mp_o[0] !== (k == 60)) begin
        bad++;
        $display("[TB] FAIL count60 tick%0d got sec=%0d mp=%0b want sec=%0d mp=%0b",
                 k, sec_o[0], mp_o[0], k % 60, (k == 60));
      end
    end
    total++;
    if (min_o[0] !== 6'd1 || pulses != 1) begin
      bad++;
      $display("[TB] FAIL count60_min got min=%0d pulses=%0d want min=1 pulses=1", min_o[0], pulses);
    end
  endtask

  task test_day_wrap();
    load_time(23, 59, 58, 1'b0);
    step(1'b1);
    total++;
    if ({mp_o[0], hp_o[0], dp_o[0]} !== 3'b000 || sec_o[0] !== 6'd59) begin
      bad++;
      $display("[TB] FAIL daywrap_pre got sec=%0d pulses=%b want sec=59 pulses=000",
               sec_o[0], {mp_o[0], hp_o[0], dp_o[0]});
    end
    step(1'b1);
    total++;
    if ({hr_o[0], min_o[0], sec_o[0]} !== 17'd0 || {mp_o[0], hp_o[0], dp_o[0]} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL daywrap got=%0d:%0d:%0d pulses=%b want=0:0:0 pulses=111",
               hr_o[0], min_o[0], sec_o[0], {mp_o[0], hp_o[0], dp_o[0]});
    end
  endtask

  task test_12h();
    load_time(11, 59, 59, 1'b0);
    step(1'b1);
    total++;
    if ({hr_o[1], min_o[1], sec_o[1], pm_o[1]} !== {5'd12, 6'd0, 6'd0, 1'b1} || dp_o[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL h12_noon got=%0d:%0d:%0d pm%0b dp=%0b want=12:0:0 pm1 dp=0",
               hr_o[1], min_o[1], sec_o[1], pm_o[1], dp_o[1]);
    end
    load_time(12, 59, 59, 1'b1);
    step(1'b1);
    total++;
    if ({hr_o[1], min_o[1], sec_o[1], pm_o[1]} !== {5'd1, 6'd0, 6'd0, 1'b1} || dp_o[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL h12_one got=%0d:%0d:%0d pm%0b dp=%0b want=1:0:0 pm1 dp=0",
               hr_o[1], min_o[1], sec_o[1], pm_o[1], dp_o[1]);
    end
    load_time(11, 59, 59, 1'b1);
    step(1'b1);
    total++;
    if ({hr_o[1], pm_o[1], mp_o[1], hp_o[1], dp_o[1]} !== {5'd12, 1'b0, 3'b111}) begin
      bad++;
      $display("[TB] FAIL h12_midnight got hr=%0d pm%0b pulses=%b want hr=12 pm0 pulses=111",
               hr_o[1], pm_o[1], {mp_o[1], hp_o[1], dp_o[1]});
    end
  endtask

  task test_divider();
    load_time(0, 0, 0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      total++;
      if (sec_o[2] !== 6'd0) begin
        bad++;
        $display("[TB] FAIL div_hold tick%0d got sec=%0d want 0", k, sec_o[2]);
      end
    end
    step(1'b1);
    total++;
    if (sec_o[2] !== 6'd1) begin
      bad++;
      $display("[TB] FAIL div_adv got sec=%0d want 1", sec_o[2]);
    end
    step(1'b1);
    step(1'b1);
    set = 1'b1; set_hr = 5'd0; set_min = 6'd0; set_sec = 6'd5;
    step(1'b1);
    set = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      total++;
      if (sec_o[2] !== 6'd5) begin
        bad++;
        $display("[TB] FAIL div_after_set tick%0d got sec=%0d want 5", k, sec_o[2]);
      end
    end
    step(1'b1);
    total++;
    if (sec_o[2] !== 6'd6) begin
      bad++;
      $display("[TB] FAIL div_after_set_adv got sec=%0d want 6", sec_o[2]);
    end
  endtask

  task test_saturate();
    set = 1'b1; set_sec = 6'd63; set_min = 6'd60; set_hr = 5'd31; set_pm = 1'b1;
    step(1'b1);
    total++;
    if ({hr_o[0], min_o[0], sec_o[0], pm_o[0]} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
      bad++;
      $display("[TB] FAIL sat24 got=%0d:%0d:%0d pm%0b want=23:59:59 pm0",
               hr_o[0], min_o[0], sec_o[0], pm_o[0]);
    end
    total++;
    if ({hr_o[1], pm_o[1]} !== {5'd12, 1'b1}) begin
      bad++;
      $display("[TB] FAIL sat12_hi got hr=%0d pm%0b want hr=12 pm1", hr_o[1], pm_o[1]);
    end
    set_hr = 5'd0; set_pm = 1'b0;
    step(1'b0);
    total++;
    if ({hr_o[1], pm_o[1]} !== {5'd12, 1'b0}) begin
      bad++;
      $display("[TB] FAIL sat12_zero got hr=%0d pm%0b want hr=12 pm0", hr_o[1], pm_o[1]);
    end
    set = 1'b0;
  endtask

  task test_async_reset();
    load_time(10, 20, 59, 1'b0);
    step(1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({hr_o[0], min_o[0], sec_o[0], mp_o[0], hp_o[0], dp_o[0]} !== 20'd0) begin
      bad++;
      $display("[TB] FAIL async_rst got=%0d:%0d:%0d pulses=%b want=0:0:0 pulses=000",
               hr_o[0], min_o[0], sec_o[0], {mp_o[0], hp_o[0], dp_o[0]});
    end
    total++;
    if ({hr_o[1], min_o[1], sec_o[1], pm_o[1]} !== {5'd12, 6'd0, 6'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_rst12 got=%0d:%0d:%0d pm%0b want=12:0:0 pm0",
               hr_o[1], min_o[1], sec_o[1], pm_o[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1);
    total++;
    if ({hr_o[0], min_o[0], sec_o[0]} !== {5'd0, 6'd0, 6'd1}) begin
      bad++;
      $display("[TB] FAIL async_resume got=%0d:%0d:%0d want=0:0:1", hr_o[0], min_o[0], sec_o[0]);
    end
  endtask

  task test_random();
    logic [17:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      set = ($urandom_range(0, 24) == 0);
      if (set) begin
        if ($urandom_range(0, 1) == 1) begin
          set_sec = 6'($urandom_range(56, 63));
          set_min = 6'($urandom_range(57, 63));
        end else begin
          set_sec = 6'($urandom_range(0, 63));
          set_min = 6'($urandom_range(0, 63));
        end
        set_hr = 5'($urandom_range(0, 31));
        set_pm = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 3; i++) begin
        got = {hr_o[i], min_o[i], sec_o[i], pm_o[i]};
        exp = {5'(exp_hr(i)), 6'(m_min[i]), 6'(m_sec[i]), exp_pm(i)};
        total++;
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL rand_time cyc%0d dut%0d got=%0d:%0d:%0d pm%0b want=%0d:%0d:%0d pm%0b",
                   n, i, hr_o[i], min_o[i], sec_o[i], pm_o[i],
                   exp_hr(i), m_min[i], m_sec[i], exp_pm(i));
        end
        total++;
        if ({mp_o[i], hp_o[i], dp_o[i]} !== {m_mp[i], m_hp[i], m_dp[i]}) begin
          bad++;
          $display("[TB] FAIL rand_pulse cyc%0d dut%0d got=%b want=%b",
                   n, i, {mp_o[i], hp_o[i], dp_o[i]}, {m_mp[i], m_hp[i], m_dp[i]});
        end
      end
    end
    set = 1'b0;
  endtask

  initial begin
    $display("[TB] starting time_of_day_counter bench");
    test_reset();
    test_count_60();
    test_day_wrap();
    test_12h();
    test_divider();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
